aer_transmitter: RTL and testbench

Downstream stage of the priority encoder in the AER chain. Each clock cycle it samples the encoder's address output, queues every valid address in a small FIFO, and sends queued addresses off-chip one at a time over a four-phase req/ack handshake. It decouples the encoder's one-event-per-cycle rate from a slower, asynchronous receiver, and flags any events it loses.

---
 rtl/aer_transmitter.sv | 145 ++++++++++++++
 tb/tb_aer_transmitter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aer_transmitter.sv
// aer_transmitter: queues encoder addresses in a small FIFO and sends them off-chip over a four-phase req/ack link.
// Optional build macro AER_ACK_SYNC_EN inserts a two-flop synchroniser on aer_ack.
//
// state   | meaning
// IDLE    | no handshake open; pops the queue head when one is waiting
// REQ     | aer_req high with aer_addr held, waiting for ack to rise
// RELEASE | aer_req low with aer_addr held, waiting for ack to fall
module aer_transmitter #(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] NULL_ADDR  = {ADDR_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic                  aer_ack,
  output logic                  aer_req,
  output logic [ADDR_WIDTH-1:0] aer_addr,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic                    req_nxt;
  logic [ADDR_WIDTH-1:0]   addr_nxt;
  logic                    pop;
  logic                    push;
  logic                    push_ok;

  logic [ADDR_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count;

  logic                    ack_s;

`ifdef AER_ACK_SYNC_EN
  logic ack_meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= aer_ack;
      ack_s    <= ack_meta;
    end
  end
`else
  assign ack_s = aer_ack;
`endif

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);

  // A full queue still accepts an event when the head leaves on the same edge.
  assign push    = (addr_in != NULL_ADDR);
  assign push_ok = push && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= addr_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      aer_req  <= 1'b0;
      aer_addr <= NULL_ADDR;
    end else begin
      state    <= state_nxt;
      aer_req  <= req_nxt;
      aer_addr <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_nxt   = aer_req;
    addr_nxt  = aer_addr;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          req_nxt   = 1'b1;
          addr_nxt  = mem[rd_ptr];
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ack_s) begin
          req_nxt   = 1'b0;
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!ack_s) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        req_nxt   = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_aer_transmitter.sv
// tb_aer_transmitter: randomized and directed stimulus for aer_transmitter, checked every cycle
// against a queue-based model of the transmitter's observable behaviour.
module tb_aer_transmitter;

  localparam logic [3:0] NULL_A = 4'hF;
  localparam int         DEPTH  = 4;
`ifdef AER_ACK_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] addr_in = NULL_A;
  logic       aer_ack = 1'b0;
  logic       aer_req;
  logic [3:0] aer_addr;
  logic       fifo_empty;
  logic       fifo_full;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  aer_transmitter dut (
    .clk       (clk),
    .reset     (reset),
    .addr_in   (addr_in),
    .aer_ack   (aer_ack),
    .aer_req   (aer_req),
    .aer_addr  (aer_addr),
    .fifo_empty(fifo_empty),
    .fifo_full (fifo_full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue contents, current bus word, and which half of the handshake is open.
  logic [3:0] m_q[$];
  logic       m_req = 1'b0;
  logic [3:0] m_addr = NULL_A;
  int         m_phase = 0;
  logic       m_ovf = 1'b0;
  logic       h0 = 1'b0, h1 = 1'b0;
  bit         model_valid = 1'b0;

  always @(posedge clk) begin : model_step
    logic ack_seen;
`ifdef AER_ACK_SYNC_EN
    ack_seen = h1;
`else
    ack_seen = aer_ack;
`endif
    if (reset) begin
      m_q.delete();
      m_req   = 1'b0;
      m_addr  = NULL_A;
      m_phase = 0;
      m_ovf   = 1'b0;
      h0      = 1'b0;
      h1      = 1'b0;
      model_valid = 1'b1;
    end else begin
      if (m_phase == 0 && m_q.size() > 0) begin
        m_addr  = m_q.pop_front();
        m_req   = 1'b1;
        m_phase = 1;
      end else if (m_phase == 1 && ack_seen) begin
        m_req   = 1'b0;
        m_phase = 2;
      end else if (m_phase == 2 && !ack_seen) begin
        m_phase = 0;
      end
      if (addr_in != NULL_A) begin
        if (m_q.size() < DEPTH) m_q.push_back(addr_in);
        else m_ovf = 1'b1;
      end
      h1 = h0;
      h0 = aer_ack;
    end
  end

  logic [3:0] sent_log[$];
  logic       prev_req = 1'b0;

  always @(negedge clk) begin
    if (model_valid) begin
      check("aer_req", int'(aer_req), int'(m_req));
      check("aer_addr", int'(aer_addr), int'(m_addr));
      check("fifo_empty", int'(fifo_empty), int'(m_q.size() == 0));
      check("fifo_full", int'(fifo_full), int'(m_q.size() == DEPTH));
      check("overflow", int'(overflow), int'(m_ovf));
    end
    if (aer_req && !prev_req) sent_log.push_back(aer_addr);
    prev_req = aer_req;
  end

  // Receiver: random response delays when enabled, otherwise aer_ack is left to the directed tests.
  bit rx_auto = 1'b0;
  int rx_cnt = 0;
  int rx_delay = 0;

  always @(negedge clk) begin
    if (rx_auto) begin
      if (aer_req != aer_ack) begin
        if (rx_cnt >= rx_delay) begin
          aer_ack  = aer_req;
          rx_cnt   = 0;
          rx_delay = $urandom_range(0, 3);
        end else begin
          rx_cnt++;
        end
      end else begin
        rx_cnt = 0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    addr_in = NULL_A;
    @(negedge clk);
    reset = 1'b0;
    sent_log.delete();
  endtask

  task automatic send_seq(input logic [3:0] v);
    @(negedge clk);
    addr_in = v;
  endtask

  initial begin
    int req_seen;
    logic [3:0] exp_full[6];
    exp_full = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd9};

    // Reset values
    do_reset();
    check("rst_req", int'(aer_req), 0);
    check("rst_addr", int'(aer_addr), 15);
    check("rst_empty", int'(fifo_empty), 1);
    check("rst_full", int'(fifo_full), 0);
    check("rst_ovf", int'(overflow), 0);

    // Single event with a manual receiver
    aer_ack = 1'b0;
    send_seq(4'd3);
    send_seq(NULL_A);
    check("single_req_wait", int'(aer_req), 0);
    check("single_queued", int'(fifo_empty), 0);
    @(negedge clk);
    check("single_req", int'(aer_req), 1);
    check("single_addr", int'(aer_addr), 3);
    @(negedge clk);
    @(negedge clk);
    aer_ack = 1'b1;
    for (int i = 0; i < SYNC_LAT; i++) begin
      @(negedge clk);
      check("single_req_held", int'(aer_req), 1);
    end
    @(negedge clk);
    check("single_req_fall", int'(aer_req), 0);
    aer_ack = 1'b0;
    repeat (6) @(negedge clk);
    check("single_empty_end", int'(fifo_empty), 1);
    check("single_count", sent_log.size(), 1);

    // Burst order with random receiver
    do_reset();
    rx_auto = 1'b1;
    send_seq(4'd4);
    send_seq(4'd3);
    send_seq(4'd1);
    send_seq(NULL_A);
    repeat (60) @(negedge clk);
    check("burst_count", sent_log.size(), 3);
    if (sent_log.size() == 3) begin
      check("burst_0", int'(sent_log[0]), 4);
      check("burst_1", int'(sent_log[1]), 3);
      check("burst_2", int'(sent_log[2]), 1);
    end
    check("burst_ovf", int'(overflow), 0);
    rx_auto = 1'b0;

    // Overflow with ack held low
    do_reset();
    aer_ack = 1'b0;
    for (int i = 0; i < 6; i++) send_seq(4'(i));
    send_seq(NULL_A);
    check("ovf_full", int'(fifo_full), 1);
    check("ovf_flag", int'(overflow), 1);
    check("ovf_addr", int'(aer_addr), 0);
    rx_auto = 1'b1;
    repeat (80) @(negedge clk);
    check("ovf_sent", sent_log.size(), 5);
    if (sent_log.size() == 5)
      for (int i = 0; i < 5; i++) check("ovf_order", int'(sent_log[i]), i);
    check("ovf_sticky", int'(overflow), 1);
    rx_auto = 1'b0;

    // Full queue with a push on the popping edge
    do_reset();
    aer_ack = 1'b0;
    for (int i = 0; i < 5; i++) send_seq(4'(i));
    send_seq(NULL_A);
    check("fp_full_before", int'(fifo_full), 1);
    aer_ack = 1'b1;
    repeat (1 + SYNC_LAT) @(negedge clk);
    aer_ack = 1'b0;
    repeat (1 + SYNC_LAT) @(negedge clk);
    addr_in = 4'd9;
    @(negedge clk);
    addr_in = NULL_A;
    check("fp_full_after", int'(fifo_full), 1);
    check("fp_ovf", int'(overflow), 0);
    check("fp_addr", int'(aer_addr), 1);
    rx_auto = 1'b1;
    repeat (80) @(negedge clk);
    check("fp_sent", sent_log.size(), 6);
    if (sent_log.size() == 6)
      for (int i = 0; i < 6; i++) check("fp_order", int'(sent_log[i]), int'(exp_full[i]));
    rx_auto = 1'b0;

    // Reset in REQ with two entries queued, ack high across the reset
    do_reset();
    aer_ack = 1'b0;
    send_seq(4'd4);
    send_seq(4'd3);
    send_seq(4'd1);
    @(negedge clk);
    addr_in = NULL_A;
    check("mid_in_req", int'(aer_req), 1);
    reset   = 1'b1;
    aer_ack = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_req", int'(aer_req), 0);
    check("mid_addr", int'(aer_addr), 15);
    check("mid_empty", int'(fifo_empty), 1);
    check("mid_ovf", int'(overflow), 0);
    repeat (3) @(negedge clk);
    aer_ack = 1'b0;

    // Idle input
    req_seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (aer_req || !fifo_empty) req_seen++;
    end
    check("idle_quiet", req_seen, 0);

    // Random traffic
    do_reset();
    rx_auto = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) addr_in = NULL_A;
      else addr_in = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    addr_in = NULL_A;
    repeat (100) @(negedge clk);
    check("rand_drained", int'(fifo_empty), 1);
    check("rand_req_low", int'(aer_req), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
